maptable_smt_ckpt: RTL and testbench

//  Rename map table with SMT and branch checkpoints. One arch->phys map per thread.

---
 rtl/maptable_smt_ckpt_pkg.sv | 74 +++++++
 rtl/maptable_smt_ckpt_pool.sv | 97 +++++++++
 rtl/maptable_smt_ckpt.sv | 127 ++++++++++++
 tb/tb_maptable_smt_ckpt.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maptable_smt_ckpt_pkg.sv
// Shared types for the SMT rename map table and its checkpoint pool.
package sys_defs;

  localparam int unsigned DP_NUM     = 2;
  localparam int unsigned CDB_NUM    = 2;
  localparam int unsigned THREAD_NUM = 2;
  localparam int unsigned AR_NUM     = 32;
  localparam int unsigned PR_NUM     = 64;
  localparam int unsigned CKPT_NUM   = 4;
  localparam int unsigned ROB_NUM    = 32;

  localparam int unsigned AR_IDX_W   = $clog2(AR_NUM);
  localparam int unsigned TAG_W      = $clog2(PR_NUM);
  localparam int unsigned CKPT_IDX_W = $clog2(CKPT_NUM);
  localparam int unsigned THR_IDX_W  = $clog2(THREAD_NUM);
  localparam int unsigned DP_IDX_W   = $clog2(DP_NUM);
  localparam int unsigned ROB_IDX_W  = $clog2(ROB_NUM);

  typedef struct packed {
    logic [AR_IDX_W-1:0]  rs1;
    logic [AR_IDX_W-1:0]  rs2;
    logic                 read_en;
    logic [THR_IDX_W-1:0] thread_idx;
  } DP_MT_READ;

  typedef struct packed {
    logic [AR_IDX_W-1:0]  rd;
    logic [TAG_W-1:0]     tag;
    logic                 write_en;
    logic [THR_IDX_W-1:0] thread_idx;
  } DP_MT_WRITE;

  typedef struct packed {
    logic [TAG_W-1:0] tag1;
    logic             tag1_ready;
    logic [TAG_W-1:0] tag2;
    logic             tag2_ready;
    logic [TAG_W-1:0] tag_old;
  } MT_DP;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [THR_IDX_W-1:0] thread_idx;
    logic                 br_result;
  } CDB;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
  } AMT_ENTRY;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
  } MT_ENTRY;

  typedef struct packed {
    logic                       valid;
    logic [THR_IDX_W-1:0]       thread_idx;
    MT_ENTRY [AR_NUM-1:0]       map;
  } CKPT_ENTRY;

  function automatic logic cdb_hit(input CDB [CDB_NUM-1:0] cdb,
                                   input logic [THR_IDX_W-1:0] thr,
                                   input logic [TAG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int unsigned c = 0; c < CDB_NUM; c++)
      if (cdb[c].valid && cdb[c].thread_idx == thr && cdb[c].tag == tag) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/maptable_smt_ckpt_pool.sv
// Checkpoint pool: free mask, younger-than matrix, snapshots kept ready-current by the CDB.
module mt_ckpt_pool
  import sys_defs::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  CDB [CDB_NUM-1:0]      cdb_i,
  input  logic [THREAD_NUM-1:0] rollback_i,
  input  logic                  alloc_req_i,
  input  logic [THR_IDX_W-1:0]  alloc_thread_i,
  input  MT_ENTRY [AR_NUM-1:0]  alloc_map_i,
  input  logic                  br_valid_i,
  input  logic [CKPT_IDX_W-1:0] br_ckpt_i,
  input  logic                  br_mispred_i,
  output logic                  ack_o,
  output logic [CKPT_IDX_W-1:0] id_o,
  output logic                  full_o,
  output logic                  restore_o,
  output logic [THR_IDX_W-1:0]  restore_thread_o,
  output MT_ENTRY [AR_NUM-1:0]  restore_map_o
);

  CKPT_ENTRY [CKPT_NUM-1:0]               ckpt_q, ckpt_d, ckpt_cdb;
  logic [CKPT_NUM-1:0][CKPT_NUM-1:0]      younger_q, younger_d;
  logic                                   full_q, full_d;
  logic [CKPT_NUM-1:0]                    freed;
  logic                                   resolve_ok, found;
  logic                                   cdb_unused;

  assign cdb_unused = ^{cdb_i[0].rob_idx, cdb_i[0].br_result, cdb_i[1].rob_idx, cdb_i[1].br_result};
  assign full_o     = full_q;

  always_comb begin
    ckpt_cdb = ckpt_q;
    for (int unsigned i = 0; i < CKPT_NUM; i++)
      for (int unsigned r = 0; r < AR_NUM; r++)
        if (ckpt_q[i].valid && cdb_hit(cdb_i, ckpt_q[i].thread_idx, ckpt_q[i].map[r].tag))
          ckpt_cdb[i].map[r].ready = 1'b1;
    resolve_ok       = br_valid_i && ckpt_q[br_ckpt_i].valid && !rollback_i[ckpt_q[br_ckpt_i].thread_idx];
    restore_o        = resolve_ok && br_mispred_i;
    restore_thread_o = ckpt_q[br_ckpt_i].thread_idx;
    restore_map_o    = ckpt_cdb[br_ckpt_i].map;
    id_o  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < CKPT_NUM; i++)
      if (!ckpt_q[i].valid && !found) begin
        id_o  = CKPT_IDX_W'(i);
        found = 1'b1;
      end
    ack_o = alloc_req_i && !full_q && !rollback_i[alloc_thread_i] &&
            !(restore_o && restore_thread_o == alloc_thread_i);
  end

  // Releases land first; the new id is then linked under every surviving same-thread id.
  always_comb begin
    freed = '0;
    for (int unsigned i = 0; i < CKPT_NUM; i++)
      if (ckpt_q[i].valid && rollback_i[ckpt_q[i].thread_idx]) freed[i] = 1'b1;
    if (resolve_ok) begin
      freed[br_ckpt_i] = 1'b1;
      if (br_mispred_i) freed = freed | younger_q[br_ckpt_i];
    end
    ckpt_d    = ckpt_cdb;
    younger_d = younger_q;
    for (int unsigned i = 0; i < CKPT_NUM; i++)
      if (freed[i]) begin
        ckpt_d[i].valid = 1'b0;
        younger_d[i]    = '0;
        for (int unsigned j = 0; j < CKPT_NUM; j++) younger_d[j][i] = 1'b0;
      end
    if (ack_o) begin
      ckpt_d[id_o].valid      = 1'b1;
      ckpt_d[id_o].thread_idx = alloc_thread_i;
      ckpt_d[id_o].map        = alloc_map_i;
      younger_d[id_o]         = '0;
      for (int unsigned i = 0; i < CKPT_NUM; i++)
        if (ckpt_d[i].valid && ckpt_d[i].thread_idx == alloc_thread_i && CKPT_IDX_W'(i) != id_o)
          younger_d[i][id_o] = 1'b1;
    end
    full_d = 1'b1;
    for (int unsigned i = 0; i < CKPT_NUM; i++)
      if (!ckpt_d[i].valid) full_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ckpt_q    <= '0;
      younger_q <= '0;
      full_q    <= 1'b0;
    end else begin
      ckpt_q    <= ckpt_d;
      younger_q <= younger_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: rtl/maptable_smt_ckpt.sv
// SMT rename map table: per-thread maps, intra-group bypass, checkpoint restore and AMT rollback.
module maptable_smt_ckpt
  import sys_defs::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [THREAD_NUM-1:0]                 rollback_i,
  input  AMT_ENTRY [THREAD_NUM-1:0][AR_NUM-1:0] amt_i,
  input  CDB [CDB_NUM-1:0]                      cdb_i,
  input  DP_MT_READ [DP_NUM-1:0]                dp_mt_read_i,
  input  DP_MT_WRITE [DP_NUM-1:0]               dp_mt_write_i,
  input  logic                                  ckpt_req_i,
  input  logic [DP_IDX_W-1:0]                   ckpt_slot_i,
  output logic                                  ckpt_ack_o,
  output logic [CKPT_IDX_W-1:0]                 ckpt_id_o,
  output logic                                  ckpt_full_o,
  input  logic                                  br_valid_i,
  input  logic [CKPT_IDX_W-1:0]                 br_ckpt_i,
  input  logic                                  br_mispred_i,
  output MT_DP [DP_NUM-1:0]                     mt_dp_o
);

  MT_ENTRY [THREAD_NUM-1:0][AR_NUM-1:0]              map_q, map_d, work;
  MT_ENTRY [DP_NUM-1:0][THREAD_NUM-1:0][AR_NUM-1:0]  stage;
  MT_ENTRY [AR_NUM-1:0]                              restore_map;
  MT_ENTRY [DP_NUM-1:0]                              rd1_e, rd2_e, old_e;
  logic [THREAD_NUM-1:0]                             drop;
  logic [DP_NUM-1:0]                                 wen;
  logic                                              restore;
  logic [THR_IDX_W-1:0]                              restore_thr, alloc_thr;
  logic                                              in_unused;

  assign in_unused = ^{cdb_i[0].rob_idx, cdb_i[0].br_result, cdb_i[1].rob_idx, cdb_i[1].br_result,
                       dp_mt_read_i[0].read_en, dp_mt_read_i[1].read_en};
  assign alloc_thr = dp_mt_read_i[ckpt_slot_i].thread_idx;

  function automatic MT_ENTRY lookup(input MT_ENTRY [AR_NUM-1:0] m, input DP_MT_WRITE [DP_NUM-1:0] w,
                                     input logic [DP_NUM-1:0] en, input logic [THR_IDX_W-1:0] thr,
                                     input logic [AR_IDX_W-1:0] r, input int unsigned k);
    MT_ENTRY e;
    e = m[r];
    for (int unsigned j = 0; j < DP_NUM; j++)
      if (j < k && en[j] && w[j].thread_idx == thr && w[j].rd == r) e = {w[j].tag, 1'b0};
    return e;
  endfunction

  mt_ckpt_pool u_pool (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cdb_i            (cdb_i),
    .rollback_i       (rollback_i),
    .alloc_req_i      (ckpt_req_i),
    .alloc_thread_i   (alloc_thr),
    .alloc_map_i      (stage[ckpt_slot_i][alloc_thr]),
    .br_valid_i       (br_valid_i),
    .br_ckpt_i        (br_ckpt_i),
    .br_mispred_i     (br_mispred_i),
    .ack_o            (ckpt_ack_o),
    .id_o             (ckpt_id_o),
    .full_o           (ckpt_full_o),
    .restore_o        (restore),
    .restore_thread_o (restore_thr),
    .restore_map_o    (restore_map)
  );

  always_comb begin
    for (int unsigned t = 0; t < THREAD_NUM; t++)
      drop[t] = rollback_i[t] | (restore && restore_thr == THR_IDX_W'(t));
    for (int unsigned k = 0; k < DP_NUM; k++)
      wen[k] = dp_mt_write_i[k].write_en && (dp_mt_write_i[k].rd != '0) &&
               !drop[dp_mt_write_i[k].thread_idx];
  end

  // stage[k] is the map after CDB wakeup and slots 0..k; writes override the wakeup.
  always_comb begin
    work = map_q;
    for (int unsigned t = 0; t < THREAD_NUM; t++)
      for (int unsigned r = 0; r < AR_NUM; r++)
        if (cdb_hit(cdb_i, THR_IDX_W'(t), map_q[t][r].tag)) work[t][r].ready = 1'b1;
    for (int unsigned k = 0; k < DP_NUM; k++) begin
      for (int unsigned t = 0; t < THREAD_NUM; t++)
        if (wen[k] && dp_mt_write_i[k].thread_idx == THR_IDX_W'(t))
          work[t][dp_mt_write_i[k].rd] = {dp_mt_write_i[k].tag, 1'b0};
      stage[k] = work;
    end
  end

  always_comb begin
    mt_dp_o = '0;
    for (int unsigned k = 0; k < DP_NUM; k++) begin
      rd1_e[k] = lookup(map_q[dp_mt_read_i[k].thread_idx], dp_mt_write_i, wen,
                        dp_mt_read_i[k].thread_idx, dp_mt_read_i[k].rs1, k);
      rd2_e[k] = lookup(map_q[dp_mt_read_i[k].thread_idx], dp_mt_write_i, wen,
                        dp_mt_read_i[k].thread_idx, dp_mt_read_i[k].rs2, k);
      old_e[k] = lookup(map_q[dp_mt_write_i[k].thread_idx], dp_mt_write_i, wen,
                        dp_mt_write_i[k].thread_idx, dp_mt_write_i[k].rd, k);
      mt_dp_o[k].tag1       = rd1_e[k].tag;
      mt_dp_o[k].tag1_ready = rd1_e[k].ready | cdb_hit(cdb_i, dp_mt_read_i[k].thread_idx, rd1_e[k].tag);
      mt_dp_o[k].tag2       = rd2_e[k].tag;
      mt_dp_o[k].tag2_ready = rd2_e[k].ready | cdb_hit(cdb_i, dp_mt_read_i[k].thread_idx, rd2_e[k].tag);
      mt_dp_o[k].tag_old    = old_e[k].tag;
    end
  end

  always_comb begin
    map_d = stage[DP_NUM-1];
    for (int unsigned t = 0; t < THREAD_NUM; t++) begin
      if (rollback_i[t]) begin
        for (int unsigned r = 0; r < AR_NUM; r++) map_d[t][r] = {amt_i[t][r].tag, 1'b1};
      end else if (restore && restore_thr == THR_IDX_W'(t)) begin
        map_d[t] = restore_map;
      end
      map_d[t][0] = {{TAG_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < THREAD_NUM; t++)
        for (int unsigned r = 0; r < AR_NUM; r++)
          map_q[t][r] <= {TAG_W'(r), 1'b1};
    end else begin
      map_q <= map_d;
    end
  end

endmodule

// File: tb/tb_maptable_smt_ckpt.sv
// Directed and random stimulus against a behavioural rename/checkpoint model.
module tb_maptable_smt_ckpt;
  import sys_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [THREAD_NUM-1:0]                 rollback;
  AMT_ENTRY [THREAD_NUM-1:0][AR_NUM-1:0] amt;
  CDB [CDB_NUM-1:0]                      cdb;
  DP_MT_READ [DP_NUM-1:0]                rd_in;
  DP_MT_WRITE [DP_NUM-1:0]               wr_in;
  logic                                  ckpt_req;
  logic [DP_IDX_W-1:0]                   ckpt_slot;
  logic                                  ckpt_ack;
  logic [CKPT_IDX_W-1:0]                 ckpt_id;
  logic                                  ckpt_full;
  logic                                  br_valid;
  logic [CKPT_IDX_W-1:0]                 br_ckpt;
  logic                                  br_mispred;
  MT_DP [DP_NUM-1:0]                     mt_dp;

  int checks = 0;
  int errors = 0;

  // Reference state: plain tag/ready tables and a checkpoint list ordered by allocation sequence.
  int mtag[THREAD_NUM][AR_NUM], ntag[THREAD_NUM][AR_NUM];
  bit mrdy[THREAD_NUM][AR_NUM], nrdy[THREAD_NUM][AR_NUM];
  bit cv[CKPT_NUM], ncv[CKPT_NUM];
  int cthr[CKPT_NUM], ncthr[CKPT_NUM];
  int cseq[CKPT_NUM], ncseq[CKPT_NUM];
  int ctag[CKPT_NUM][AR_NUM], nctag[CKPT_NUM][AR_NUM];
  bit crdy[CKPT_NUM][AR_NUM], ncrdy[CKPT_NUM][AR_NUM];
  int seqc = 0;

  always #5 clk = ~clk;

  maptable_smt_ckpt dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rollback_i    (rollback),
    .amt_i         (amt),
    .cdb_i         (cdb),
    .dp_mt_read_i  (rd_in),
    .dp_mt_write_i (wr_in),
    .ckpt_req_i    (ckpt_req),
    .ckpt_slot_i   (ckpt_slot),
    .ckpt_ack_o    (ckpt_ack),
    .ckpt_id_o     (ckpt_id),
    .ckpt_full_o   (ckpt_full),
    .br_valid_i    (br_valid),
    .br_ckpt_i     (br_ckpt),
    .br_mispred_i  (br_mispred),
    .mt_dp_o       (mt_dp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_cdb(input int t, input int tag);
    for (int c = 0; c < CDB_NUM; c++)
      if (cdb[c].valid && int'(cdb[c].thread_idx) == t && int'(cdb[c].tag) == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_lookup(input int t, input int r, input int k, input bit [DP_NUM-1:0] wen,
                                   output int tag, output bit rdy);
    if (r == 0) begin
      tag = 0; rdy = 1'b1;
      return;
    end
    tag = mtag[t][r]; rdy = mrdy[t][r];
    for (int j = 0; j < k; j++)
      if (wen[j] && int'(wr_in[j].thread_idx) == t && int'(wr_in[j].rd) == r) begin
        tag = int'(wr_in[j].tag); rdy = 1'b0;
      end
    rdy = rdy | m_cdb(t, tag);
  endfunction

  task automatic idle();
    rollback = '0; cdb = '0; rd_in = '0; wr_in = '0;
    ckpt_req = 1'b0; ckpt_slot = '0; br_valid = 1'b0; br_ckpt = '0; br_mispred = 1'b0;
  endtask

  task automatic set_rd(input int k, input int thr, input int rs1, input int rs2);
    rd_in[k].thread_idx = THR_IDX_W'(thr); rd_in[k].rs1 = AR_IDX_W'(rs1);
    rd_in[k].rs2 = AR_IDX_W'(rs2); rd_in[k].read_en = 1'b1;
  endtask

  task automatic set_wr(input int k, input int thr, input int rd, input int tag);
    wr_in[k].thread_idx = THR_IDX_W'(thr); wr_in[k].rd = AR_IDX_W'(rd);
    wr_in[k].tag = TAG_W'(tag); wr_in[k].write_en = 1'b1;
  endtask

  // Settles inputs, checks every combinational output, and prepares the model's next state.
  task automatic eval();
    bit rok, rest, eack, rr, allv;
    int br, rthr, athr, eid, tg;
    bit [DP_NUM-1:0] wen;
    int stag[AR_NUM];
    bit srdy[AR_NUM];
    #1;
    br   = int'(br_ckpt);
    rok  = br_valid && cv[br] && !rollback[cthr[br]];
    rest = rok && br_mispred;
    rthr = cthr[br];
    for (int k = 0; k < DP_NUM; k++) begin
      int t;
      t = int'(wr_in[k].thread_idx);
      wen[k] = wr_in[k].write_en && wr_in[k].rd != 0 && !(rollback[t] || (rest && rthr == t));
    end
    for (int k = 0; k < DP_NUM; k++) begin
      if (rd_in[k].read_en) begin
        m_lookup(int'(rd_in[k].thread_idx), int'(rd_in[k].rs1), k, wen, tg, rr);
        chk($sformatf("tag1[%0d]", k), 32'(mt_dp[k].tag1), 32'(tg));
        chk($sformatf("rdy1[%0d]", k), 32'(mt_dp[k].tag1_ready), 32'(rr));
        m_lookup(int'(rd_in[k].thread_idx), int'(rd_in[k].rs2), k, wen, tg, rr);
        chk($sformatf("tag2[%0d]", k), 32'(mt_dp[k].tag2), 32'(tg));
        chk($sformatf("rdy2[%0d]", k), 32'(mt_dp[k].tag2_ready), 32'(rr));
      end
      if (wr_in[k].write_en) begin
        m_lookup(int'(wr_in[k].thread_idx), int'(wr_in[k].rd), k, wen, tg, rr);
        chk($sformatf("tag_old[%0d]", k), 32'(mt_dp[k].tag_old), 32'(tg));
      end
    end
    allv = 1'b1; eid = -1;
    for (int i = 0; i < CKPT_NUM; i++) begin
      if (!cv[i]) allv = 1'b0;
      if (!cv[i] && eid < 0) eid = i;
    end
    athr = int'(rd_in[ckpt_slot].thread_idx);
    eack = ckpt_req && !allv && !rollback[athr] && !(rest && rthr == athr);
    chk("ckpt_full", 32'(ckpt_full), 32'(allv));
    chk("ckpt_ack", 32'(ckpt_ack), 32'(eack));
    if (eack) chk("ckpt_id", 32'(ckpt_id), 32'(eid));
    for (int t = 0; t < THREAD_NUM; t++) begin
      for (int r = 0; r < AR_NUM; r++) begin
        ntag[t][r] = mtag[t][r];
        nrdy[t][r] = mrdy[t][r] | m_cdb(t, mtag[t][r]);
        if (rollback[t]) begin
          ntag[t][r] = int'(amt[t][r].tag); nrdy[t][r] = 1'b1;
        end else if (rest && rthr == t) begin
          ntag[t][r] = ctag[br][r]; nrdy[t][r] = crdy[br][r] | m_cdb(t, ctag[br][r]);
        end
      end
      if (!rollback[t] && !(rest && rthr == t))
        for (int k = 0; k < DP_NUM; k++)
          if (wen[k] && int'(wr_in[k].thread_idx) == t) begin
            ntag[t][wr_in[k].rd] = int'(wr_in[k].tag); nrdy[t][wr_in[k].rd] = 1'b0;
          end
      ntag[t][0] = 0; nrdy[t][0] = 1'b1;
    end
    for (int r = 0; r < AR_NUM; r++) begin
      stag[r] = mtag[athr][r]; srdy[r] = mrdy[athr][r] | m_cdb(athr, mtag[athr][r]);
    end
    for (int k = 0; k <= int'(ckpt_slot); k++)
      if (wen[k] && int'(wr_in[k].thread_idx) == athr) begin
        stag[wr_in[k].rd] = int'(wr_in[k].tag); srdy[wr_in[k].rd] = 1'b0;
      end
    ncv = cv; ncthr = cthr; ncseq = cseq; nctag = ctag;
    for (int i = 0; i < CKPT_NUM; i++)
      for (int r = 0; r < AR_NUM; r++)
        ncrdy[i][r] = crdy[i][r] | (cv[i] && m_cdb(cthr[i], ctag[i][r]));
    for (int i = 0; i < CKPT_NUM; i++)
      if (cv[i] && rollback[cthr[i]]) ncv[i] = 1'b0;
    if (rok) begin
      ncv[br] = 1'b0;
      if (br_mispred)
        for (int i = 0; i < CKPT_NUM; i++)
          if (cv[i] && cthr[i] == rthr && cseq[i] > cseq[br]) ncv[i] = 1'b0;
    end
    if (eack) begin
      ncv[eid] = 1'b1; ncthr[eid] = athr; ncseq[eid] = seqc;
      for (int r = 0; r < AR_NUM; r++) begin
        nctag[eid][r] = stag[r]; ncrdy[eid][r] = srdy[r];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mtag = ntag; mrdy = nrdy;
    if (ckpt_ack === 1'b1 || ncv != cv) seqc++;
    cv = ncv; cthr = ncthr; cseq = ncseq; ctag = nctag; crdy = ncrdy;
    idle();
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < DP_NUM; k++) begin
      set_rd(k, $urandom_range(0, THREAD_NUM-1), $urandom_range(0, AR_NUM-1), $urandom_range(0, AR_NUM-1));
      rd_in[k].read_en = ($urandom_range(0, 7) != 0);
      set_wr(k, $urandom_range(0, THREAD_NUM-1), $urandom_range(0, AR_NUM-1), $urandom_range(1, PR_NUM-1));
      wr_in[k].write_en = ($urandom_range(0, 2) != 0);
    end
    for (int c = 0; c < CDB_NUM; c++) begin
      int t;
      t = $urandom_range(0, THREAD_NUM-1);
      cdb[c].valid = ($urandom_range(0, 1) != 0);
      cdb[c].thread_idx = THR_IDX_W'(t);
      cdb[c].tag = ($urandom_range(0, 1) != 0) ? TAG_W'(mtag[t][$urandom_range(0, AR_NUM-1)])
                                               : TAG_W'($urandom_range(0, PR_NUM-1));
      cdb[c].rob_idx = ROB_IDX_W'($urandom);
      cdb[c].br_result = 1'($urandom);
    end
    for (int t = 0; t < THREAD_NUM; t++) begin
      rollback[t] = ($urandom_range(0, 31) == 0);
      for (int r = 0; r < AR_NUM; r++) amt[t][r].tag = (r == 0) ? '0 : TAG_W'($urandom_range(0, PR_NUM-1));
    end
    ckpt_req   = ($urandom_range(0, 2) == 0);
    ckpt_slot  = DP_IDX_W'($urandom_range(0, DP_NUM-1));
    br_valid   = ($urandom_range(0, 3) == 0);
    br_ckpt    = CKPT_IDX_W'($urandom_range(0, CKPT_NUM-1));
    br_mispred = 1'($urandom);
  endtask

  initial begin
    idle();
    amt = '0;
    for (int t = 0; t < THREAD_NUM; t++)
      for (int r = 0; r < AR_NUM; r++) begin
        mtag[t][r] = r; mrdy[t][r] = 1'b1;
      end
    for (int i = 0; i < CKPT_NUM; i++) begin
      cv[i] = 1'b0; cthr[i] = 0; cseq[i] = 0;
      for (int r = 0; r < AR_NUM; r++) begin
        ctag[i][r] = 0; crdy[i][r] = 1'b0;
      end
    end
    #17 rst = 1'b0;

    // 1: reset mapping is identity and ready
    set_rd(0, 0, 0, 5); set_rd(1, 0, 7, 8);
    eval();
    chk("t1_r0", 32'({mt_dp[0].tag1, mt_dp[0].tag1_ready}), 32'({6'd0, 1'b1}));
    chk("t1_r5", 32'({mt_dp[0].tag2, mt_dp[0].tag2_ready}), 32'({6'd5, 1'b1}));
    chk("t1_r7", 32'({mt_dp[1].tag1, mt_dp[1].tag1_ready}), 32'({6'd7, 1'b1}));
    chk("t1_r8", 32'({mt_dp[1].tag2, mt_dp[1].tag2_ready}), 32'({6'd8, 1'b1}));
    chk("t1_full", 32'(ckpt_full), 32'd0);
    tick();

    // 2: intra-group bypass and same-rd priority
    set_wr(0, 0, 7, 40); set_rd(1, 0, 7, 0); set_wr(1, 0, 7, 41);
    eval();
    chk("t2_tag1", 32'({mt_dp[1].tag1, mt_dp[1].tag1_ready}), 32'({6'd40, 1'b0}));
    chk("t2_old1", 32'(mt_dp[1].tag_old), 32'd40);
    chk("t2_old0", 32'(mt_dp[0].tag_old), 32'd7);
    tick();
    set_rd(0, 0, 7, 0);
    eval();
    chk("t2_r7", 32'({mt_dp[0].tag1, mt_dp[0].tag1_ready}), 32'({6'd41, 1'b0}));
    tick();

    // 3: dispatch write beats same-cycle CDB
    set_wr(0, 0, 3, 50); set_rd(1, 0, 3, 0);
    cdb[0].valid = 1'b1; cdb[0].tag = 6'd50; cdb[0].thread_idx = '0;
    eval();
    chk("t3_fwd", 32'({mt_dp[1].tag1, mt_dp[1].tag1_ready}), 32'({6'd50, 1'b1}));
    tick();
    set_rd(0, 0, 3, 0);
    eval();
    chk("t3_stored0", 32'({mt_dp[0].tag1, mt_dp[0].tag1_ready}), 32'({6'd50, 1'b0}));
    tick();
    cdb[1].valid = 1'b1; cdb[1].tag = 6'd50; cdb[1].thread_idx = '0;
    eval();
    tick();
    set_rd(0, 0, 3, 0);
    eval();
    chk("t3_stored1", 32'({mt_dp[0].tag1, mt_dp[0].tag1_ready}), 32'({6'd50, 1'b1}));
    tick();

    // 4: checkpoint at slot0, younger checkpoint, mispredict restores older
    set_rd(0, 0, 0, 0); set_wr(0, 0, 4, 44); set_wr(1, 0, 5, 45);
    ckpt_req = 1'b1; ckpt_slot = '0;
    eval();
    chk("t4_ack0", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'd0}));
    tick();
    set_rd(0, 0, 0, 0); set_wr(0, 0, 4, 46); ckpt_req = 1'b1;
    eval();
    chk("t4_ack1", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'd1}));
    tick();
    br_valid = 1'b1; br_ckpt = 2'd0; br_mispred = 1'b1;
    eval();
    tick();
    set_rd(0, 0, 4, 5); ckpt_req = 1'b1;
    eval();
    chk("t4_r4", 32'({mt_dp[0].tag1, mt_dp[0].tag1_ready}), 32'({6'd44, 1'b0}));
    chk("t4_r5", 32'({mt_dp[0].tag2, mt_dp[0].tag2_ready}), 32'({6'd5, 1'b1}));
    chk("t4_full", 32'(ckpt_full), 32'd0);
    chk("t4_realloc", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'd0}));
    tick();
    set_rd(0, 0, 0, 0); ckpt_req = 1'b1;
    eval();
    chk("t4_young_freed", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'd1}));
    tick();

    // 5: fill pool, refuse when full, reuse released id
    for (int i = 2; i < CKPT_NUM; i++) begin
      set_rd(0, 0, 0, 0); ckpt_req = 1'b1;
      eval();
      chk("t5_fill", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'(i)}));
      tick();
    end
    set_rd(0, 0, 0, 0); ckpt_req = 1'b1;
    eval();
    chk("t5_full", 32'(ckpt_full), 32'd1);
    chk("t5_noack", 32'(ckpt_ack), 32'd0);
    tick();
    br_valid = 1'b1; br_ckpt = 2'd2;
    eval();
    tick();
    set_rd(0, 0, 0, 0); ckpt_req = 1'b1;
    eval();
    chk("t5_reuse", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'd2}));
    tick();

    // 6: thread1 rollback leaves thread0 untouched
    for (int i = 3; i >= 2; i--) begin
      br_valid = 1'b1; br_ckpt = 2'(i);
      eval();
      tick();
    end
    for (int i = 2; i < CKPT_NUM; i++) begin
      set_rd(0, 1, 0, 0); ckpt_req = 1'b1;
      eval();
      chk("t6_thr1_alloc", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'(i)}));
      tick();
    end
    for (int r = 0; r < AR_NUM; r++) amt[1][r].tag = TAG_W'(r);
    amt[1][9].tag = 6'd60;
    rollback = 2'b10; set_wr(0, 0, 10, 33);
    eval();
    tick();
    set_rd(0, 1, 9, 0); set_rd(1, 0, 10, 0);
    eval();
    chk("t6_thr1_r9", 32'({mt_dp[0].tag1, mt_dp[0].tag1_ready}), 32'({6'd60, 1'b1}));
    chk("t6_thr0_r10", 32'({mt_dp[1].tag1, mt_dp[1].tag1_ready}), 32'({6'd33, 1'b0}));
    chk("t6_full", 32'(ckpt_full), 32'd0);
    tick();
    for (int i = 2; i < CKPT_NUM; i++) begin
      set_rd(0, 0, 0, 0); ckpt_req = 1'b1;
      eval();
      chk("t6_thr0_kept", 32'({ckpt_ack, ckpt_id}), 32'({1'b1, 2'(i)}));
      tick();
    end
    eval();
    chk("t6_full_again", 32'(ckpt_full), 32'd1);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      eval();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
